// File: rtl/skew_feeder_pkg.sv
// Purpose: shared types and size helpers for the skew_feeder block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, element-count helpers for A (H*K) and B (K*W),
//           and the stream length L = max(H,W)+K-1.
package skew_feeder_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    STREAM = 2'd2
  } state_e;

  function automatic int a_elems(input int h, input int k);
    return h * k;
  endfunction

  function automatic int b_elems(input int k, input int w);
    return k * w;
  endfunction

  function automatic int stream_beats(input int h, input int w, input int k);
    return ((h > w) ? h : w) + k - 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// Purpose: picks the element and valid bit presented on one skewed lane for beat t.
// Latency: purely combinational.
// Backpressure: none; follows i_t, which the parent only advances on consumer take.
// Ports: i_en gates the lane (STREAM only), i_t beat index, i_lane lane index,
//        i_elems the K elements feeding this lane (element k at [k*width_p +: width_p]),
//        o_data / o_v lane element and validity.
module skew_lane_mux #(
  parameter int width_p = 8,
  parameter int depth_p = 2,
  parameter int cnt_w_p = 2
) (
  input  logic                       i_en,
  input  logic [cnt_w_p-1:0]         i_t,
  input  logic [cnt_w_p-1:0]         i_lane,
  input  logic [depth_p*width_p-1:0] i_elems,
  output logic [width_p-1:0]         o_data,
  output logic                       o_v
);

  logic [cnt_w_p-1:0] w_diff;

  always_comb begin
    w_diff = i_t - i_lane;
    // Lane i starts i beats late and runs for K beats.
    o_v    = i_en && (i_t >= i_lane) && (w_diff < cnt_w_p'(depth_p));
    o_data = '0;
    for (int k = 0; k < depth_p; k++) begin
      if (o_v && (w_diff == cnt_w_p'(k))) begin
        o_data = i_elems[k*width_p +: width_p];
      end
    end
  end

endmodule

// File: rtl/skew_feeder.sv
// Purpose: loads A (HxK) then B (KxW) row-major and streams them as skewed systolic wavefronts.
// Latency: STREAM begins the cycle after the final load accept; one beat per yumi_i.
// Backpressure: ready_o low during STREAM; beats hold while yumi_i is low.
// Ports: clk_i/reset_n_i (async active-low); valid_i/data_i/ready_o element input;
//        valid_o/yumi_i wavefront handshake; row_data_o/row_v_o A lanes; col_data_o/col_v_o B lanes;
//        flush_i aborts to LOAD_A; done_o pulses one cycle after the last beat is taken.
// Option: SKEW_FEEDER_KEEP_B_EN retains B across operations (LOAD_B skipped once B is loaded).
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int width_p        = 8,
  parameter int array_height_p = 2,
  parameter int array_width_p  = 2,
  parameter int depth_p        = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              valid_i,
  input  logic [width_p-1:0]                data_i,
  output logic                              ready_o,
  output logic                              valid_o,
  input  logic                              yumi_i,
  output logic [array_height_p*width_p-1:0] row_data_o,
  output logic [array_height_p-1:0]         row_v_o,
  output logic [array_width_p*width_p-1:0]  col_data_o,
  output logic [array_width_p-1:0]          col_v_o,
  input  logic                              flush_i,
  output logic                              done_o
);

  localparam int HK    = a_elems(array_height_p, depth_p);
  localparam int KW    = b_elems(depth_p, array_width_p);
  localparam int L     = stream_beats(array_height_p, array_width_p, depth_p);
  localparam int CNT_W = $clog2(max3(HK, KW, L) + 1);

  state_e             r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [CNT_W-1:0]   r_t, w_t_n;
  logic               r_done, w_done_n;
  logic [width_p-1:0] r_a [HK];
  logic [width_p-1:0] r_b [KW];
  logic               w_stream;
  logic               w_accept;
`ifdef SKEW_FEEDER_KEEP_B_EN
  logic               r_b_loaded, w_b_loaded_n;
`endif

  assign w_stream = (r_state == STREAM);
  assign ready_o  = !w_stream;
  assign valid_o  = w_stream;
  assign w_accept = valid_i && ready_o;
  assign done_o   = r_done;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_t_n     = r_t;
    w_done_n  = 1'b0;
`ifdef SKEW_FEEDER_KEEP_B_EN
    w_b_loaded_n = r_b_loaded;
`endif
    if (flush_i) begin
      w_state_n = LOAD_A;
      w_cnt_n   = '0;
      w_t_n     = '0;
`ifdef SKEW_FEEDER_KEEP_B_EN
      w_b_loaded_n = 1'b0;
`endif
    end else begin
      case (r_state)
        LOAD_A: begin
          if (w_accept) begin
            if (r_cnt == CNT_W'(HK - 1)) begin
              w_cnt_n = '0;
              w_t_n   = '0;
`ifdef SKEW_FEEDER_KEEP_B_EN
              w_state_n = r_b_loaded ? STREAM : LOAD_B;
`else
              w_state_n = LOAD_B;
`endif
            end else begin
              w_cnt_n = r_cnt + CNT_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (w_accept) begin
            if (r_cnt == CNT_W'(KW - 1)) begin
              w_cnt_n   = '0;
              w_t_n     = '0;
              w_state_n = STREAM;
`ifdef SKEW_FEEDER_KEEP_B_EN
              w_b_loaded_n = 1'b1;
`endif
            end else begin
              w_cnt_n = r_cnt + CNT_W'(1);
            end
          end
        end
        STREAM: begin
          if (yumi_i) begin
            if (r_t == CNT_W'(L - 1)) begin
              w_state_n = LOAD_A;
              w_t_n     = '0;
              w_done_n  = 1'b1;
            end else begin
              w_t_n = r_t + CNT_W'(1);
            end
          end
        end
        default: w_state_n = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= LOAD_A;
      r_cnt   <= '0;
      r_t     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_t     <= w_t_n;
      r_done  <= w_done_n;
    end
  end

`ifdef SKEW_FEEDER_KEEP_B_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_b_loaded <= 1'b0;
    else            r_b_loaded <= w_b_loaded_n;
  end
`endif

  // Matrix storage, indexed row-major by the load counter; a flush cycle writes nothing.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int n = 0; n < HK; n++) r_a[n] <= '0;
      for (int n = 0; n < KW; n++) r_b[n] <= '0;
    end else if (w_accept && !flush_i) begin
      for (int n = 0; n < HK; n++) begin
        if ((r_state == LOAD_A) && (r_cnt == CNT_W'(n))) r_a[n] <= data_i;
      end
      for (int n = 0; n < KW; n++) begin
        if ((r_state == LOAD_B) && (r_cnt == CNT_W'(n))) r_b[n] <= data_i;
      end
    end
  end

  // Row lane i sees A[i][0..K-1].
  for (genvar gi = 0; gi < array_height_p; gi++) begin : g_row
    logic [depth_p*width_p-1:0] w_elems;
    for (genvar gk = 0; gk < depth_p; gk++) begin : g_k
      assign w_elems[gk*width_p +: width_p] = r_a[gi*depth_p + gk];
    end
    skew_lane_mux #(
      .width_p(width_p),
      .depth_p(depth_p),
      .cnt_w_p(CNT_W)
    ) u_mux (
      .i_en   (w_stream),
      .i_t    (r_t),
      .i_lane (CNT_W'(gi)),
      .i_elems(w_elems),
      .o_data (row_data_o[gi*width_p +: width_p]),
      .o_v    (row_v_o[gi])
    );
  end

  // Column lane j sees B[0..K-1][j].
  for (genvar gj = 0; gj < array_width_p; gj++) begin : g_col
    logic [depth_p*width_p-1:0] w_elems;
    for (genvar gk = 0; gk < depth_p; gk++) begin : g_k
      assign w_elems[gk*width_p +: width_p] = r_b[gk*array_width_p + gj];
    end
    skew_lane_mux #(
      .width_p(width_p),
      .depth_p(depth_p),
      .cnt_w_p(CNT_W)
    ) u_mux (
      .i_en   (w_stream),
      .i_t    (r_t),
      .i_lane (CNT_W'(gj)),
      .i_elems(w_elems),
      .o_data (col_data_o[gj*width_p +: width_p]),
      .o_v    (col_v_o[gj])
    );
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Purpose: self-checking bench for skew_feeder with default parameters (2x2x2, 8-bit).
// Latency: n/a.
// Backpressure: n/a.
// Honours SKEW_FEEDER_KEEP_B_EN when the design is built with it.
module tb_skew_feeder;

  localparam int WD = 8;
  localparam int H  = 2;
  localparam int W  = 2;
  localparam int K  = 2;
  localparam int HK = H * K;
  localparam int KW = K * W;
  localparam int L  = ((H > W) ? H : W) + K - 1;
`ifdef SKEW_FEEDER_KEEP_B_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          valid_i;
  logic [WD-1:0] data_i;
  logic          ready_o;
  logic          valid_o;
  logic          yumi_i;
  logic [H*WD-1:0] row_data_o;
  logic [H-1:0]    row_v_o;
  logic [W*WD-1:0] col_data_o;
  logic [W-1:0]    col_v_o;
  logic          flush_i;
  logic          done_o;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model: matrices plus where we are in the operation.
  logic [WD-1:0] ma [H][K];
  logic [WD-1:0] mb [K][W];
  bit m_stream = 0;
  int m_cnt    = 0;
  int m_t      = 0;
  bit m_done   = 0;
  bit m_bvalid = 0;
  bit b_kept   = 0;

  skew_feeder #(
    .width_p(WD), .array_height_p(H), .array_width_p(W), .depth_p(K)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .valid_o(valid_o), .yumi_i(yumi_i),
    .row_data_o(row_data_o), .row_v_o(row_v_o),
    .col_data_o(col_data_o), .col_v_o(col_v_o),
    .flush_i(flush_i), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int need, idx;
    if (!reset_n_i) begin
      m_stream = 0; m_cnt = 0; m_t = 0; m_done = 0; m_bvalid = 0;
      return;
    end
    m_done = 0;
    if (flush_i) begin
      m_stream = 0; m_cnt = 0; m_t = 0; m_bvalid = 0;
    end else if (!m_stream) begin
      if (valid_i) begin
        idx = m_cnt;
        if (idx < HK) ma[idx / K][idx % K] = data_i;
        else          mb[(idx - HK) / W][(idx - HK) % W] = data_i;
        m_cnt++;
        need = (KEEP && m_bvalid) ? HK : HK + KW;
        if (m_cnt == need) begin
          m_stream = 1; m_t = 0; m_cnt = 0;
          if (KEEP) m_bvalid = 1;
        end
      end
    end else if (yumi_i) begin
      if (m_t == L - 1) begin
        m_stream = 0; m_done = 1; m_t = 0;
      end else begin
        m_t++;
      end
    end
  endtask

  task automatic compare();
    logic [H*WD-1:0] e_row;
    logic [W*WD-1:0] e_col;
    logic [H-1:0]    e_rv;
    logic [W-1:0]    e_cv;
    bit act;
    int d;
    e_row = '0; e_col = '0; e_rv = '0; e_cv = '0;
    act = reset_n_i && m_stream;
    if (act) begin
      for (int i = 0; i < H; i++) begin
        d = m_t - i;
        if (d >= 0 && d < K) begin e_row[i*WD +: WD] = ma[i][d]; e_rv[i] = 1'b1; end
      end
      for (int j = 0; j < W; j++) begin
        d = m_t - j;
        if (d >= 0 && d < K) begin e_col[j*WD +: WD] = mb[d][j]; e_cv[j] = 1'b1; end
      end
    end
    chk("cyc_ready", ready_o, !act);
    chk("cyc_valid", valid_o, act);
    chk("cyc_done", done_o, reset_n_i && m_done);
    chk("cyc_row_data", row_data_o, e_row);
    chk("cyc_row_v", row_v_o, e_rv);
    chk("cyc_col_data", col_data_o, e_col);
    chk("cyc_col_v", col_v_o, e_cv);
  endtask

  initial forever begin @(posedge clk_i); model_step(); end
  initial forever begin @(negedge clk_i); compare(); end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic send(input logic [WD-1:0] d);
    valid_i = 1'b1; data_i = d;
    tick();
    valid_i = 1'b0; data_i = '0;
  endtask

  task automatic load_op(input logic [WD-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
    send(a0); send(a1); send(a2); send(a3);
    if (!b_kept) begin
      send(b0); send(b1); send(b2); send(b3);
    end
    b_kept = KEEP;
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 20 && !valid_o; n++) tick();
    chk("wait_valid", valid_o, 1'b1);
  endtask

  task automatic stream_all();
    wait_valid();
    yumi_i = 1'b1;
    repeat (L) tick();
    yumi_i = 1'b0;
    chk("done_pulse", done_o, 1'b1);
  endtask

  initial begin
    reset_n_i = 1'b0; valid_i = 1'b0; data_i = '0; yumi_i = 1'b0; flush_i = 1'b0;
    #12;
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_lanes", {row_v_o, col_v_o, row_data_o, col_data_o}, '0);
    tick();
    reset_n_i = 1'b1;
    tick();

    // Reference operation with stall and valid_i held high during STREAM.
    load_op(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    valid_i = 1'b1; data_i = 8'hEE;
    chk("t0_valid", valid_o, 1'b1);
    chk("t0_row", row_data_o, 16'h0001); chk("t0_row_v", row_v_o, 2'b01);
    chk("t0_col", col_data_o, 16'h0005); chk("t0_col_v", col_v_o, 2'b01);
    yumi_i = 1'b1; tick(); yumi_i = 1'b0;
    chk("t1_row", row_data_o, 16'h0302); chk("t1_row_v", row_v_o, 2'b11);
    chk("t1_col", col_data_o, 16'h0607); chk("t1_col_v", col_v_o, 2'b11);
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("hold_row", row_data_o, 16'h0302);
      chk("hold_col", col_data_o, 16'h0607);
      chk("hold_v", {row_v_o, col_v_o, valid_o, ready_o}, 6'b1111_10);
    end
    yumi_i = 1'b1; tick();
    chk("t2_row", row_data_o, 16'h0400); chk("t2_row_v", row_v_o, 2'b10);
    chk("t2_col", col_data_o, 16'h0800); chk("t2_col_v", col_v_o, 2'b10);
    valid_i = 1'b0; data_i = '0;
    tick(); yumi_i = 1'b0;
    chk("t2_done", done_o, 1'b1);
    chk("after_valid", valid_o, 1'b0);
    chk("after_ready", ready_o, 1'b1);
    tick();
    chk("done_one_cycle", done_o, 1'b0);

    // Next load must start at A[0][0]: nothing from STREAM was consumed.
    load_op(8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17);
    wait_valid();
    chk("fresh_a00", row_data_o, 16'h000A);
    stream_all();
    tick();

    // Flush after the third A element.
    send(8'd21); send(8'd22); send(8'd23);
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    b_kept = 1'b0;
    chk("flush_ready", ready_o, 1'b1);
    chk("flush_valid", valid_o, 1'b0);
    chk("flush_done", done_o, 1'b0);
    load_op(8'd31, 8'd32, 8'd33, 8'd34, 8'd5, 8'd6, 8'd7, 8'd8);
    wait_valid();
    chk("flush_t0_row", row_data_o, 16'h001F);
    chk("flush_t0_col", col_data_o, 16'h0005);
    stream_all();
    tick();

`ifdef SKEW_FEEDER_KEEP_B_EN
    // B retained: four A accepts go straight to STREAM.
    send(8'd9); send(8'd9); send(8'd9); send(8'd9);
    chk("keep_stream", valid_o, 1'b1);
    chk("keep_t0_col", col_data_o, 16'h0005);
    yumi_i = 1'b1; tick();
    chk("keep_t1_col", col_data_o, 16'h0607);
    chk("keep_t1_row", row_data_o, 16'h0909);
    tick();
    chk("keep_t2_col", col_data_o, 16'h0800);
    tick(); yumi_i = 1'b0;
    chk("keep_done", done_o, 1'b1);
    tick();
`endif

    // Reset during STREAM t1.
    load_op(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    wait_valid();
    yumi_i = 1'b1; tick(); yumi_i = 1'b0;
    chk("pre_rst_t1", row_data_o, 16'h0302);
    reset_n_i = 1'b0;
    #1;
    chk("midrst_valid", valid_o, 1'b0);
    chk("midrst_ready", ready_o, 1'b1);
    chk("midrst_lanes", {row_v_o, col_v_o, row_data_o, col_data_o}, '0);
    tick();
    reset_n_i = 1'b1;
    b_kept = 1'b0;
    tick();
    load_op(8'd40, 8'd41, 8'd42, 8'd43, 8'd44, 8'd45, 8'd46, 8'd47);
    wait_valid();
    chk("post_rst_row", row_data_o, 16'h0028);
    chk("post_rst_col", col_data_o, 16'h002C);
    stream_all();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
